// File: rtl/mor1kx_wb_stage_cappuccino.sv
// Cappuccino write-back stage: latches the control-stage instruction on advance,
// selects and aligns its result, and drives the GPR write port and retire counter.
module mor1kx_wb_stage_cappuccino #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_wb_i,
    input  logic                            pipeline_flush_i,
    input  logic                            ctrl_valid_i,
    input  logic                            ctrl_rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i,
    input  logic                            ctrl_op_lsu_load_i,
    input  logic                            ctrl_op_mfspr_i,
    input  logic                            ctrl_op_mul_i,
    input  logic [1:0]                      ctrl_lsu_length_i,
    input  logic                            ctrl_lsu_zext_i,
    input  logic [1:0]                      ctrl_lsu_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_dat_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_dat_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] mul_result_i,
    output logic                            wb_rf_wb_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] result_o,
    output logic [31:0]                     wb_retired_cnt_o
);

    localparam int OW = OPTION_OPERAND_WIDTH;

    logic                            adv;
    logic [7:0]                      load_byte;
    logic [15:0]                     load_half;
    logic [OW-1:0]                   load_data;
    logic [OW-1:0]                   sel_result;

    logic                            wb_rf_wb_d,       wb_rf_wb_q;
    logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_d,     wb_rfd_adr_q;
    logic [OW-1:0]                   result_d,         result_q;
    logic [31:0]                     wb_retired_cnt_d, wb_retired_cnt_q;

    assign adv = padv_wb_i & ~pipeline_flush_i;

    // Big-endian bus: lowest byte address lives in the most significant lane.
    always_comb begin
        load_byte = 8'h00;
        case (ctrl_lsu_adr_i)
            2'd0:    load_byte = lsu_dat_i[31:24];
            2'd1:    load_byte = lsu_dat_i[23:16];
            2'd2:    load_byte = lsu_dat_i[15:8];
            default: load_byte = lsu_dat_i[7:0];
        endcase

        load_half = ctrl_lsu_adr_i[1] ? lsu_dat_i[15:0] : lsu_dat_i[31:16];

        load_data = lsu_dat_i;
        case (ctrl_lsu_length_i)
            2'b00: load_data = ctrl_lsu_zext_i ? {{(OW-8){1'b0}}, load_byte}
                                               : {{(OW-8){load_byte[7]}}, load_byte};
            2'b01: load_data = ctrl_lsu_zext_i ? {{(OW-16){1'b0}}, load_half}
                                               : {{(OW-16){load_half[15]}}, load_half};
            default: load_data = lsu_dat_i;
        endcase
    end

    always_comb begin
        if (ctrl_op_lsu_load_i)
            sel_result = load_data;
        else if (ctrl_op_mfspr_i)
            sel_result = spr_dat_i;
        else if (ctrl_op_mul_i)
            sel_result = mul_result_i;
        else
            sel_result = ctrl_alu_result_i;
    end

    // Result and address hold between advances so the bypass path stays valid.
    always_comb begin
        wb_rf_wb_d       = 1'b0;
        wb_rfd_adr_d     = wb_rfd_adr_q;
        result_d         = result_q;
        wb_retired_cnt_d = wb_retired_cnt_q;
        if (adv) begin
            wb_rf_wb_d   = ctrl_valid_i & ctrl_rf_wb_i & (ctrl_rfd_adr_i != '0);
            wb_rfd_adr_d = ctrl_rfd_adr_i;
            result_d     = sel_result;
            if (ctrl_valid_i)
                wb_retired_cnt_d = wb_retired_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_rf_wb_q       <= 1'b0;
            wb_rfd_adr_q     <= '0;
            result_q         <= '0;
            wb_retired_cnt_q <= 32'd0;
        end else begin
            wb_rf_wb_q       <= wb_rf_wb_d;
            wb_rfd_adr_q     <= wb_rfd_adr_d;
            result_q         <= result_d;
            wb_retired_cnt_q <= wb_retired_cnt_d;
        end
    end

    assign wb_rf_wb_o       = wb_rf_wb_q;
    assign wb_rfd_adr_o     = wb_rfd_adr_q;
    assign result_o         = result_q;
    assign wb_retired_cnt_o = wb_retired_cnt_q;

endmodule

// File: tb/tb_mor1kx_wb_stage_cappuccino.sv
// Scoreboard bench for the cappuccino write-back stage: directed cases followed
// by random traffic, checked against a behavioural model of the stage.
module tb_mor1kx_wb_stage_cappuccino;

    logic        clk = 1'b0;
    logic        rst;
    logic        padv_wb_i, pipeline_flush_i, ctrl_valid_i, ctrl_rf_wb_i;
    logic [4:0]  ctrl_rfd_adr_i;
    logic [31:0] ctrl_alu_result_i;
    logic        ctrl_op_lsu_load_i, ctrl_op_mfspr_i, ctrl_op_mul_i;
    logic [1:0]  ctrl_lsu_length_i;
    logic        ctrl_lsu_zext_i;
    logic [1:0]  ctrl_lsu_adr_i;
    logic [31:0] lsu_dat_i, spr_dat_i, mul_result_i;
    logic        wb_rf_wb_o;
    logic [4:0]  wb_rfd_adr_o;
    logic [31:0] result_o;
    logic [31:0] wb_retired_cnt_o;

    mor1kx_wb_stage_cappuccino dut (
        .clk(clk), .rst(rst),
        .padv_wb_i(padv_wb_i), .pipeline_flush_i(pipeline_flush_i),
        .ctrl_valid_i(ctrl_valid_i), .ctrl_rf_wb_i(ctrl_rf_wb_i),
        .ctrl_rfd_adr_i(ctrl_rfd_adr_i), .ctrl_alu_result_i(ctrl_alu_result_i),
        .ctrl_op_lsu_load_i(ctrl_op_lsu_load_i), .ctrl_op_mfspr_i(ctrl_op_mfspr_i),
        .ctrl_op_mul_i(ctrl_op_mul_i), .ctrl_lsu_length_i(ctrl_lsu_length_i),
        .ctrl_lsu_zext_i(ctrl_lsu_zext_i), .ctrl_lsu_adr_i(ctrl_lsu_adr_i),
        .lsu_dat_i(lsu_dat_i), .spr_dat_i(spr_dat_i), .mul_result_i(mul_result_i),
        .wb_rf_wb_o(wb_rf_wb_o), .wb_rfd_adr_o(wb_rfd_adr_o),
        .result_o(result_o), .wb_retired_cnt_o(wb_retired_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wb;
        logic [4:0]  adr;
        logic [31:0] res;
        logic [31:0] cnt;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    logic        m_wb;
    logic [4:0]  m_adr;
    logic [31:0] m_res;
    logic [31:0] m_cnt;
    string       cur_tag;

    function automatic logic [31:0] ref_load(input logic [31:0] dat, input logic [1:0] len,
                                             input logic [1:0] off, input logic zext);
        int          shift;
        logic [31:0] mask, v;
        if (len == 2'b00) begin
            shift = (3 - int'(off)) * 8;
            mask  = 32'h0000_00FF;
        end else if (len == 2'b01) begin
            shift = off[1] ? 0 : 16;
            mask  = 32'h0000_FFFF;
        end else begin
            shift = 0;
            mask  = 32'hFFFF_FFFF;
        end
        v = (dat >> shift) & mask;
        if (!zext && mask != 32'hFFFF_FFFF && ((v & ~(mask >> 1)) != 0))
            v = v | ~mask;
        return v;
    endfunction

    // Advance the model by one clock with the currently driven inputs and queue the outcome.
    task automatic apply();
        exp_t e;
        if (rst) begin
            m_wb = 0; m_adr = 0; m_res = 0; m_cnt = 0;
        end else if (padv_wb_i && !pipeline_flush_i) begin
            if (ctrl_op_lsu_load_i)
                m_res = ref_load(lsu_dat_i, ctrl_lsu_length_i, ctrl_lsu_adr_i, ctrl_lsu_zext_i);
            else if (ctrl_op_mfspr_i)
                m_res = spr_dat_i;
            else if (ctrl_op_mul_i)
                m_res = mul_result_i;
            else
                m_res = ctrl_alu_result_i;
            m_adr = ctrl_rfd_adr_i;
            m_wb  = ctrl_valid_i && ctrl_rf_wb_i && ctrl_rfd_adr_i != 0;
            if (ctrl_valid_i) m_cnt = m_cnt + 1;
        end else begin
            m_wb = 0;
        end
        e.wb = m_wb; e.adr = m_adr; e.res = m_res; e.cnt = m_cnt; e.tag = cur_tag;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rst = 0; padv_wb_i = 0; pipeline_flush_i = 0; ctrl_valid_i = 0; ctrl_rf_wb_i = 0;
        ctrl_rfd_adr_i = 0; ctrl_alu_result_i = 0; ctrl_op_lsu_load_i = 0;
        ctrl_op_mfspr_i = 0; ctrl_op_mul_i = 0; ctrl_lsu_length_i = 0; ctrl_lsu_zext_i = 0;
        ctrl_lsu_adr_i = 0; lsu_dat_i = 0; spr_dat_i = 0; mul_result_i = 0;
    endtask

    // One retiring instruction followed by an idle (hold) cycle.
    task automatic issue(input string tag, input logic [4:0] rd);
        cur_tag = tag;
        padv_wb_i = 1; ctrl_valid_i = 1; ctrl_rf_wb_i = 1; ctrl_rfd_adr_i = rd;
        apply();
        padv_wb_i = 0;
        cur_tag = {tag, "_hold"};
        apply();
    endtask

    task automatic load(input string tag, input logic [1:0] len, input logic [1:0] off,
                        input logic zext);
        ctrl_op_lsu_load_i = 1; ctrl_lsu_length_i = len; ctrl_lsu_adr_i = off;
        ctrl_lsu_zext_i = zext; lsu_dat_i = 32'h80F1_7F02;
        issue(tag, 5'd7);
        ctrl_op_lsu_load_i = 0;
    endtask

    function automatic void check(input string name, input string tag,
                                  input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s: got %h, expected %h", tag, name, got, want);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wb_rf_wb",   e.tag, {31'b0, wb_rf_wb_o}, {31'b0, e.wb});
                check("rfd_adr",    e.tag, {27'b0, wb_rfd_adr_o}, {27'b0, e.adr});
                check("result",     e.tag, result_o, e.res);
                check("retire_cnt", e.tag, wb_retired_cnt_o, e.cnt);
            end
        end
    end

    initial begin : stimulus
        clear_inputs();
        m_wb = 0; m_adr = 0; m_res = 0; m_cnt = 0;
        rst = 1; cur_tag = "reset";
        apply(); apply();
        rst = 0;

        ctrl_alu_result_i = 32'h1234_5678;
        issue("alu", 5'd3);
        ctrl_alu_result_i = 32'h0BAD_F00D;

        load("lb_off1_sext", 2'b00, 2'd1, 1'b0);
        load("lb_off3_zext", 2'b00, 2'd3, 1'b1);
        load("lh_off0_sext", 2'b01, 2'd0, 1'b0);
        load("lh_off2_zext", 2'b01, 2'd2, 1'b1);
        load("lw",           2'b10, 2'd1, 1'b0);
        load("lw_len3",      2'b11, 2'd2, 1'b1);

        ctrl_op_mul_i = 1; mul_result_i = 32'h1111_1111;
        load("prio_load_mul", 2'b00, 2'd1, 1'b0);
        issue("mul", 5'd9);
        ctrl_op_mul_i = 0;

        ctrl_op_mfspr_i = 1; spr_dat_i = 32'hDEAD_BEEF;
        issue("mfspr", 5'd12);
        ctrl_op_mfspr_i = 0;

        issue("r0_write", 5'd0);

        ctrl_alu_result_i = 32'h5555_AAAA;
        cur_tag = "invalid";
        padv_wb_i = 1; ctrl_valid_i = 0; ctrl_rfd_adr_i = 5'd4;
        apply();

        cur_tag = "flush";
        ctrl_valid_i = 1; pipeline_flush_i = 1; ctrl_rfd_adr_i = 5'd6;
        ctrl_alu_result_i = 32'hCAFE_0001;
        apply();
        pipeline_flush_i = 0; padv_wb_i = 0;
        cur_tag = "flush_hold";
        apply();

        ctrl_alu_result_i = 32'h0000_0042;
        cur_tag = "b2b";
        padv_wb_i = 1; ctrl_rfd_adr_i = 5'd10;
        apply();
        ctrl_rfd_adr_i = 5'd11;
        apply();
        cur_tag = "rst_with_adv";
        rst = 1;
        apply();
        rst = 0; padv_wb_i = 0;
        cur_tag = "after_rst";
        apply();

        // Jump the retire counter close to its wrap point instead of 2^32 retirements.
        dut.wb_retired_cnt_q = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        issue("cnt_ffffffff", 5'd2);
        issue("cnt_wrap", 5'd2);

        for (int i = 0; i < 400; i++) begin
            cur_tag = $sformatf("rand%0d", i);
            rst                = ($urandom_range(0, 49) == 0);
            padv_wb_i          = ($urandom_range(0, 9) < 7);
            pipeline_flush_i   = ($urandom_range(0, 9) < 2);
            ctrl_valid_i       = ($urandom_range(0, 9) < 8);
            ctrl_rf_wb_i       = ($urandom_range(0, 9) < 8);
            ctrl_rfd_adr_i     = 5'($urandom_range(0, 31));
            ctrl_alu_result_i  = $urandom;
            ctrl_op_lsu_load_i = 1'($urandom_range(0, 1));
            ctrl_op_mfspr_i    = 1'($urandom_range(0, 1));
            ctrl_op_mul_i      = 1'($urandom_range(0, 1));
            ctrl_lsu_length_i  = 2'($urandom_range(0, 3));
            ctrl_lsu_zext_i    = 1'($urandom_range(0, 1));
            ctrl_lsu_adr_i     = 2'($urandom_range(0, 3));
            lsu_dat_i          = $urandom;
            spr_dat_i          = $urandom;
            mul_result_i       = $urandom;
            apply();
        end
        clear_inputs();
        cur_tag = "drain";
        apply();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
